// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : proc_pkg
//  Purpose  : Shared types and constants for the data-memory responder slice:
//             FSM state encoding, default base address and data width.
//  Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // Data path width of the processor data interface
  localparam int DATA_W = 32;

  // Byte address that maps to RAM word 0 unless overridden
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;

  // Responder FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT,
    DONE = ST_DONE
  } state_t;

  // Latency counter is wide enough for the largest legal LATENCY (15)
  localparam int CNT_W = 4;

endpackage : proc_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : Single-port word RAM with registered read. Contents are not
//             affected by reset; the responder FSM owns all control.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_array
  import proc_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port and read-first registered read share one index
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    rdata <= mem_q[idx];
  end

endmodule : dmem_array
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Slave end of the processor data interface. Accepts one word
//             read/write at a time, completes it LATENCY edges later with a
//             one-cycle dReady pulse (dErr for bad requests), backed by a
//             word RAM mapped at BASE_ADDR.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import proc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dAddress,
  input  logic [DATA_W-1:0] dWriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic [DATA_W-1:0] dReadData,
  output logic              dReady,
  output logic              dErr,
  output logic              busy
);

  // Request-side decode of the live bus (only meaningful in IDLE)
  logic [31:0]       w_off;
  logic              w_below;
  logic              w_above;
  logic              w_misalign;
  logic              w_req_err;
  logic [IDX_W-1:0]  w_req_idx;

  // RAM interface
  logic              w_ram_we;
  logic [IDX_W-1:0]  w_ram_idx;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_commit;

  // FSM and captured request
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_read_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              derr_q;
  logic              busy_q;

  // Range, alignment and strobe-conflict check; index is taken only after
  // the range check so truncation to IDX_W never aliases a legal word
  always_comb begin
    w_off      = dAddress - BASE_ADDR;
    w_below    = (dAddress < BASE_ADDR);
    w_above    = !w_below && (w_off >= 32'(4 * DEPTH));
    w_misalign = (dAddress[1:0] != 2'b00);
    w_req_err  = w_below || w_above || w_misalign || (MemRead && MemWrite);
    w_req_idx  = w_off[IDX_W+1:2];
  end

  // RAM control: while idle the RAM pre-reads the bus index so that the
  // registered read data is already stable by the completing edge, even
  // for LATENCY=1. A write commits only at WAIT->DONE and never under reset.
  always_comb begin
    w_commit  = (state_q == WAIT) && (cnt_q == '0);
    w_ram_we  = w_commit && !is_read_q && !err_q && !rst;
    w_ram_idx = (state_q == IDLE) ? w_req_idx : idx_q;
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_dmem_array (
    .clk   (clk),
    .we    (w_ram_we),
    .idx   (w_ram_idx),
    .wdata (wdata_q),
    .rdata (w_ram_rdata)
  );

  // Responder FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      derr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      derr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MemRead || MemWrite) begin
            idx_q     <= w_req_idx;
            wdata_q   <= dWriteData;
            is_read_q <= MemRead;
            err_q     <= w_req_err;
            cnt_q     <= CNT_W'(LATENCY - 1);
            busy_q    <= 1'b1;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            derr_q  <= err_q;
            if (is_read_q) begin
              rdata_q <= err_q ? '0 : w_ram_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dReadData = rdata_q;
  assign dReady    = ready_q;
  assign dErr      = derr_q;
  assign busy      = busy_q;

endmodule : data_mem_responder
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder. Three instances
//             (LATENCY 2, 1, 15) share clock, reset and address/data buses
//             but have private strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  mr, mw, rdy, derr, bsy;
  logic [31:0] rdat0, rdat1, rdat2;
  int          lat_of [3] = '{2, 1, 15};

  always #5 clk = ~clk;

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .dAddress(addr), .dWriteData(wdata),
    .MemRead(mr[0]), .MemWrite(mw[0]), .dReadData(rdat0),
    .dReady(rdy[0]), .dErr(derr[0]), .busy(bsy[0]));

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .dAddress(addr), .dWriteData(wdata),
    .MemRead(mr[1]), .MemWrite(mw[1]), .dReadData(rdat1),
    .dReady(rdy[1]), .dErr(derr[1]), .busy(bsy[1]));

  data_mem_responder #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .dAddress(addr), .dWriteData(wdata),
    .MemRead(mr[2]), .MemWrite(mw[2]), .dReadData(rdat2),
    .dReady(rdy[2]), .dErr(derr[2]), .busy(bsy[2]));

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic        err;
    logic [31:0] edata;
    bit          chk_data;
  } vec_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] rdat(int k);
    case (k)
      0:       return rdat0;
      1:       return rdat1;
      default: return rdat2;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample at negedges until dReady; n counts rising edges after the
  // accepting edge, nb counts sampled cycles with busy high.
  task automatic wait_ready(int k, output int n, output int nb, output bit ok);
    n  = 0;
    nb = 0;
    ok = 1'b0;
    while (n <= 40) begin
      @(negedge clk);
      if (bsy[k]) nb++;
      if (rdy[k]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  // Pop the oldest expectation and compare the completion it describes
  task automatic score(int k, string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, " dErr"}, 32'(derr[k]), 32'(e.err));
      if (e.chk_data) chk({name, " dReadData"}, rdat(k), e.data);
    end
  endtask

  // One complete request: drive, accept, scramble bus, await and score
  task automatic req(int k, bit r, bit w, logic [31:0] a, logic [31:0] d,
                     logic eerr, logic [31:0] edata, bit cd, string name);
    int n, nb;
    bit ok;
    @(negedge clk);
    addr  = a;
    wdata = d;
    mr[k] = r;
    mw[k] = w;
    sb.push_back('{eerr, edata, cd});
    @(posedge clk);
    #1;
    mr[k] = 1'b0;
    mw[k] = 1'b0;
    addr  = 32'hFFFF_FFF0;
    wdata = ~d;
    wait_ready(k, n, nb, ok);
    chk({name, " dReady seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({name, " latency"}, 32'(n), 32'(lat_of[k]));
      chk({name, " busy cycles"}, 32'(nb), 32'(lat_of[k] + 1));
      score(k, name);
      @(posedge clk);
      @(negedge clk);
      chk({name, " dReady pulse width"}, 32'(rdy[k]), 32'd0);
      chk({name, " busy after DONE"}, 32'(bsy[k]), 32'd0);
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [14];
    int   n, nb, m, gap;
    bit   ok, ok2, stray;

    vt[0]  = '{0, 1, BASE + 32'h008, 32'hCAFE_F00D, 0, 32'h0000_0000, 1};
    vt[1]  = '{1, 0, BASE + 32'h008, 32'h0,         0, 32'hCAFE_F00D, 1};
    vt[2]  = '{1, 0, BASE + 32'h006, 32'h0,         1, 32'h0000_0000, 1};
    vt[3]  = '{1, 0, BASE + 32'h008, 32'h0,         0, 32'hCAFE_F00D, 1};
    vt[4]  = '{0, 1, BASE + 32'hFFC, 32'h1234_5678, 0, 32'hCAFE_F00D, 1};
    vt[5]  = '{0, 1, BASE + 32'h1000, 32'hDEAD_BEEF, 1, 32'hCAFE_F00D, 1};
    vt[6]  = '{1, 0, 32'h1000_FFFC,  32'h0,         1, 32'h0000_0000, 1};
    vt[7]  = '{1, 0, BASE + 32'hFFC, 32'h0,         0, 32'h1234_5678, 1};
    vt[8]  = '{1, 1, BASE + 32'h008, 32'h5555_5555, 1, 32'h0,         0};
    vt[9]  = '{0, 1, BASE + 32'h000, 32'h1111_1111, 0, 32'h0,         0};
    vt[10] = '{1, 0, BASE + 32'h000, 32'h0,         0, 32'h1111_1111, 1};
    vt[11] = '{1, 0, BASE + 32'h008, 32'h0,         0, 32'hCAFE_F00D, 1};
    vt[12] = '{0, 1, BASE + 32'h010, 32'hAAAA_5555, 0, 32'h0,         0};
    vt[13] = '{1, 0, BASE + 32'h010, 32'h0,         0, 32'hAAAA_5555, 1};

    rst   = 1'b1;
    mr    = '0;
    mw    = '0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dReady", 32'(rdy), 32'd0);
    chk("reset busy", 32'(bsy), 32'd0);
    chk("reset dErr", 32'(derr), 32'd0);
    chk("reset dReadData", rdat0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      req(0, vt[i].r, vt[i].w, vt[i].a, vt[i].d, vt[i].err, vt[i].edata,
          vt[i].chk_data, $sformatf("vec%0d", i));
    end

    // Strobe held through DONE: re-accepted in IDLE, second pulse LAT+2 later
    @(negedge clk);
    addr  = BASE + 32'h008;
    mr[0] = 1'b1;
    sb.push_back('{1'b0, 32'hCAFE_F00D, 1'b1});
    sb.push_back('{1'b0, 32'hCAFE_F00D, 1'b1});
    @(posedge clk);
    wait_ready(0, n, nb, ok);
    chk("held first latency", 32'(n), 32'd2);
    score(0, "held first");
    m   = 0;
    ok2 = 1'b0;
    while (m <= 40) begin
      @(posedge clk);
      m++;
      @(negedge clk);
      if (rdy[0]) begin
        ok2 = 1'b1;
        break;
      end
    end
    mr[0] = 1'b0;
    gap = m;
    chk("held second dReady seen", 32'(ok2), 32'd1);
    chk("held pulse spacing", 32'(gap), 32'd4);
    score(0, "held second");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("held released busy", 32'(bsy[0]), 32'd0);

    // Reset one edge into WAIT of a write: nothing committed, outputs cleared
    @(negedge clk);
    addr     = BASE + 32'h010;
    wdata    = 32'hBBBB_0000;
    mw[0]    = 1'b1;
    @(posedge clk);
    #1;
    mw[0] = 1'b0;
    @(negedge clk);
    chk("midrst busy before reset", 32'(bsy[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst dReady", 32'(rdy[0]), 32'd0);
    chk("midrst busy", 32'(bsy[0]), 32'd0);
    chk("midrst dErr", 32'(derr[0]), 32'd0);
    chk("midrst dReadData", rdat0, 32'd0);
    stray = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rdy[0] || bsy[0]) stray = 1'b1;
    end
    chk("midrst no late completion", 32'(stray), 32'd0);
    req(0, 1, 0, BASE + 32'h010, 32'h0, 0, 32'hAAAA_5555, 1, "midrst readback");

    // Extreme latency builds
    for (int k = 1; k < 3; k++) begin
      logic [31:0] v;
      v = (k == 1) ? 32'h0BAD_CAFE : 32'h1515_1515;
      req(k, 0, 1, BASE + 32'h040, v, 0, 32'h0, 1, $sformatf("lat%0d write", lat_of[k]));
      req(k, 1, 0, BASE + 32'h040, 32'h0, 0, v, 1, $sformatf("lat%0d read", lat_of[k]));
      req(k, 1, 0, BASE + 32'h042, 32'h0, 1, 32'h0, 1, $sformatf("lat%0d misaligned", lat_of[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_data_mem_responder
`default_nettype wire
